// File: rtl/sys_pio_pkg.sv
// rtl/sys_pio_pkg.sv - shared constants and edge helper for the parallel input port
// Contents: register word addresses, edge-type selectors, bus data width and
// edge_detect(), which forms the per-bit edge vector from current/previous values.
package sys_pio_pkg;

  localparam int PIO_DATA_W = 32;

  localparam logic [1:0] PIO_ADDR_DATA = 2'd0;
  localparam logic [1:0] PIO_ADDR_RSVD = 2'd1;
  localparam logic [1:0] PIO_ADDR_MASK = 2'd2;
  localparam logic [1:0] PIO_ADDR_EDGE = 2'd3;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

  function automatic logic [PIO_DATA_W-1:0] edge_detect(
    input int                    edge_type,
    input logic [PIO_DATA_W-1:0] cur,
    input logic [PIO_DATA_W-1:0] prev
  );
    case (edge_type)
      EDGE_FALL: edge_detect = ~cur & prev;
      EDGE_ANY:  edge_detect = cur ^ prev;
      default:   edge_detect = cur & ~prev;
    endcase
  endfunction

endpackage

// File: rtl/sys_pio_debounce.sv
// rtl/sys_pio_debounce.sv - single-bit debounce: stability counter plus stable register
// Ports:
//   clk, reset_n  clock, asynchronous active-low reset
//   s             synchronised input bit
//   warmup        high while the port is settling after reset; deb follows s directly
//   deb           debounced bit
module sys_pio_debounce #(
  parameter int DEBOUNCE_CYCLES = 0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic s,
  input  logic warmup,
  output logic deb
);

  localparam int CW     = (DEBOUNCE_CYCLES > 0) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
  localparam int LAST_I = (DEBOUNCE_CYCLES > 0) ? DEBOUNCE_CYCLES - 1 : 0;
  localparam logic [CW-1:0] LAST = CW'(LAST_I);

  logic [CW-1:0] cnt;

  // The counter tracks consecutive cycles in which s disagrees with deb; deb
  // only moves on the DEBOUNCE_CYCLES-th such cycle in a row.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
      deb <= 1'b0;
    end else if (warmup || (DEBOUNCE_CYCLES == 0)) begin
      cnt <= '0;
      deb <= s;
    end else if (s == deb) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
      deb <= s;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/sys_pio_in.sv
// rtl/sys_pio_in.sv - Avalon-MM parallel input port with edge capture and interrupt
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   address[1:0]        word address: 0 DATA, 1 reserved, 2 IRQ_MASK, 3 EDGE_CAP (W1C)
//   chipselect, write_n slave select and active-low write strobe
//   writedata[31:0]     write data
//   readdata[31:0]      registered read data, one cycle after the address
//   in_port[WIDTH-1:0]  asynchronous external inputs
//   irq                 level interrupt, high while any unmasked capture bit is set
module sys_pio_in
  import sys_pio_pkg::*;
#(
  parameter int WIDTH           = 32,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 0,
  parameter int EDGE_TYPE       = 0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [1:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [PIO_DATA_W-1:0] writedata,
  output logic [PIO_DATA_W-1:0] readdata,
  input  logic [WIDTH-1:0]      in_port,
  output logic                  irq
);

  localparam int WARM_LEN = SYNC_STAGES + 2;
  localparam int WW       = $clog2(WARM_LEN + 1);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] s;
  logic [WIDTH-1:0] deb;
  logic [WIDTH-1:0] prev;
  logic [WIDTH-1:0] cap;
  logic [WIDTH-1:0] mask;
  logic [WIDTH-1:0] edge_v;
  logic [WIDTH-1:0] clr;
  logic [PIO_DATA_W-1:0] edge_full;
  logic [WW-1:0]    warm_cnt;
  logic             warmup;
  logic             wr;

  // Warmup covers the sync chain filling plus deb and prev catching up, so
  // inputs already high at reset release never look like an edge.
  assign warmup = (warm_cnt != WW'(WARM_LEN));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      warm_cnt <= '0;
    end else if (warmup) begin
      warm_cnt <= warm_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= in_port;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  for (genvar g = 0; g < WIDTH; g++) begin : g_deb
    sys_pio_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .clk    (clk),
      .reset_n(reset_n),
      .s      (s[g]),
      .warmup (warmup),
      .deb    (deb[g])
    );
  end

  assign edge_full = edge_detect(EDGE_TYPE, PIO_DATA_W'(deb), PIO_DATA_W'(prev));
  assign edge_v    = warmup ? '0 : edge_full[WIDTH-1:0];

  assign wr  = chipselect && !write_n;
  assign clr = (wr && address == PIO_ADDR_EDGE) ? writedata[WIDTH-1:0] : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev     <= '0;
      cap      <= '0;
      mask     <= '0;
      irq      <= 1'b0;
      readdata <= '0;
    end else begin
      prev <= deb;
      // Clear is applied before OR-ing in new edges, so a same-cycle edge wins.
      cap  <= (cap & ~clr) | edge_v;
      if (wr && address == PIO_ADDR_MASK) mask <= writedata[WIDTH-1:0];
      irq  <= |(cap & mask);
      case (address)
        PIO_ADDR_DATA: readdata <= PIO_DATA_W'(deb);
        PIO_ADDR_MASK: readdata <= PIO_DATA_W'(mask);
        PIO_ADDR_EDGE: readdata <= PIO_DATA_W'(cap);
        default:       readdata <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_sys_pio_in.sv
// tb/tb_sys_pio_in.sv - directed self-checking bench for sys_pio_in
module tb_sys_pio_in;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] in_port;
  logic [31:0] in_port_db;
  logic [31:0] readdata;
  logic [31:0] readdata_db;
  logic        irq;
  logic        irq_db;

  int n_assert = 0;
  int n_fail   = 0;
  logic [31:0] seen;

  always #5 clk = ~clk;

  sys_pio_in dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .address   (address),
    .chipselect(chipselect),
    .write_n   (write_n),
    .writedata (writedata),
    .readdata  (readdata),
    .in_port   (in_port),
    .irq       (irq)
  );

  sys_pio_in #(
    .WIDTH(32), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(2)
  ) dut_db (
    .clk       (clk),
    .reset_n   (reset_n),
    .address   (address),
    .chipselect(chipselect),
    .write_n   (write_n),
    .writedata (writedata),
    .readdata  (readdata_db),
    .in_port   (in_port_db),
    .irq       (irq_db)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic bus_read(input logic [1:0] a);
    address = a;
    step(1);
  endtask

  initial begin
    reset_n    = 1'b0;
    address    = 2'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 32'h0;
    in_port    = 32'hFFFF_FFFF;
    in_port_db = 32'h0;

    // Reset values with inputs already high
    step(3);
    check("rst_readdata", readdata, 32'h0);
    check("rst_irq", {31'h0, irq}, 32'h0);
    reset_n = 1'b1;
    step(10);
    bus_read(2'd3);
    check("warm_edgecap", readdata, 32'h0);
    bus_read(2'd0);
    check("warm_data", readdata, 32'hFFFF_FFFF);
    check("warm_irq", {31'h0, irq}, 32'h0);

    // Rising edge on bit 0 with mask set
    in_port = 32'h0;
    step(6);
    bus_write(2'd2, 32'h1);
    address = 2'd3;
    step(1);
    in_port = 32'h1;
    step(4);
    check("rise_irq_p4", {31'h0, irq}, 32'h0);
    step(1);
    check("rise_irq_p5", {31'h0, irq}, 32'h1);
    check("rise_cap", readdata, 32'h1);
    bus_write(2'd3, 32'h1);
    check("clr_irq_p1", {31'h0, irq}, 32'h1);
    step(1);
    check("clr_irq_p2", {31'h0, irq}, 32'h0);
    check("clr_cap", readdata, 32'h0);

    // Masked edge on bit 5, then unmask
    bus_write(2'd2, 32'h0);
    in_port = 32'h21;
    step(6);
    bus_read(2'd3);
    check("mask_cap", readdata, 32'h20);
    check("mask_irq_off", {31'h0, irq}, 32'h0);
    bus_write(2'd2, 32'h20);
    check("mask_irq_same", {31'h0, irq}, 32'h0);
    step(1);
    check("mask_irq_next", {31'h0, irq}, 32'h1);

    // Same-cycle edge and clear on bit 3
    in_port = 32'h29;
    step(6);
    bus_read(2'd3);
    check("b3_first_cap", readdata, 32'h28);
    in_port = 32'h21;
    step(6);
    in_port = 32'h29;
    step(3);
    bus_write(2'd3, 32'h8);
    bus_read(2'd3);
    check("edge_wins", readdata, 32'h28);
    bus_write(2'd3, 32'h8);
    bus_read(2'd3);
    check("clr_alone", readdata, 32'h20);

    // Reserved and read-only addresses
    bus_write(2'd1, 32'hFFFF_FFFF);
    bus_write(2'd0, 32'hFFFF_FFFF);
    bus_read(2'd1);
    check("rsvd_read", readdata, 32'h0);
    bus_read(2'd2);
    check("mask_kept", readdata, 32'h20);
    bus_read(2'd0);
    check("data_val", readdata, 32'h29);

    // Debounce: short pulse filtered
    seen = 32'h0;
    in_port_db = 32'h80;
    for (int i = 0; i < 3; i++) begin step(1); seen |= readdata_db; end
    in_port_db = 32'h0;
    for (int i = 0; i < 12; i++) begin step(1); seen |= readdata_db; end
    check("db_short_data", seen, 32'h0);
    bus_read(2'd3);
    check("db_short_cap", readdata_db, 32'h0);

    // Debounce: long pulse passes, both edges captured
    address = 2'd0;
    step(1);
    seen = 32'h0;
    in_port_db = 32'h80;
    for (int i = 0; i < 6; i++) begin step(1); seen |= readdata_db; end
    in_port_db = 32'h0;
    for (int i = 0; i < 14; i++) begin step(1); seen |= readdata_db; end
    check("db_long_seen", seen, 32'h80);
    check("db_long_back", readdata_db, 32'h0);
    bus_read(2'd3);
    check("db_long_cap", readdata_db, 32'h80);

    // Reset mid-operation
    bus_write(2'd3, 32'hFFFF_FFFF);
    in_port = 32'h0;
    step(6);
    in_port = 32'hF;
    step(6);
    bus_write(2'd2, 32'hF);
    bus_read(2'd3);
    step(1);
    check("pre_rst_cap", readdata, 32'hF);
    check("pre_rst_irq", {31'h0, irq}, 32'h1);
    reset_n = 1'b0;
    #1;
    check("mid_rst_irq", {31'h0, irq}, 32'h0);
    check("mid_rst_readdata", readdata, 32'h0);
    step(1);
    reset_n = 1'b1;
    step(10);
    bus_read(2'd3);
    check("post_rst_cap", readdata, 32'h0);
    bus_read(2'd2);
    check("post_rst_mask", readdata, 32'h0);
    bus_read(2'd0);
    check("post_rst_data", readdata, 32'hF);
    check("post_rst_irq", {31'h0, irq}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/sys_pio_in.md
Name: sys_pio_in

Overview:
- Avalon-MM slave parallel input port. Complements the existing output PIO: external inputs (switches, sensor discretes) go in, the RISC-V core reads them.
- Synchronises and optionally debounces each bit, detects edges, latches them in a write-1-to-clear capture register, and raises a maskable level interrupt to the core.

Parameters:
- WIDTH, 32: number of input bits, 1..32; unused readdata bits read 0.
- SYNC_STAGES, 2: synchroniser flops per bit, minimum 2.
- DEBOUNCE_CYCLES, 0: consecutive stable cycles required before the debounced value changes; 0 bypasses debounce.
- EDGE_TYPE, 0: 0 = rising, 1 = falling, 2 = any edge.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- address  in  2  word address.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe.
- writedata  in  32  write data.
- readdata  out  32  registered read data.
- in_port  in  WIDTH  asynchronous external inputs.
- irq  out  1  level interrupt, active-high.

Behaviour:
- Reset is asynchronous, active-low (reset_n); clock is clk. Reset clears all flops: sync chain, debounced value, previous value, capture, mask, readdata and warmup counter. irq = 0 and readdata = 0 out of reset.
- Register map:
  - addr 0 DATA: RO, debounced value.
  - addr 1: reserved, reads 0, writes ignored.
  - addr 2 IRQ_MASK: RW, WIDTH bits.
  - addr 3 EDGE_CAP: read, and write-1-to-clear per bit.
- Write: chipselect && !write_n. A write to addr 0 or 1 has no effect.
- Read: readdata is registered on every clk with the selected register, zero-extended. Read latency is 1 cycle. Readdata is updated every cycle independent of chipselect, so the value is valid the cycle after the address is presented.
- Sync: in_port passes through SYNC_STAGES flops to give s.
- Debounce (DEBOUNCE_CYCLES > 0), per bit, with counter width clog2(DEBOUNCE_CYCLES+1):
  - If s != deb, the counter increments.
  - If s == deb, the counter clears.
  - When the counter reaches DEBOUNCE_CYCLES - 1 and s != deb still holds, deb <= s and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES cycles never reaches deb.
  - DEBOUNCE_CYCLES = 0: deb <= s every cycle.
- Edge detect: prev <= deb every cycle. The edge vector is:
  - rising: deb & ~prev
  - falling: ~deb & prev
  - any: deb ^ prev
- Warmup: a counter runs for SYNC_STAGES + 2 cycles after reset release.
  - During warmup, deb <= s directly (debounce bypassed) and edge capture is inhibited.
  - This avoids spurious edges from inputs already high at reset.
  - After warmup the counter saturates; the state is held until the next reset.
- Capture: cap <= (cap & ~clr) | edge, where clr = writedata[WIDTH-1:0] on a write to addr 3, else 0.
  - If a new edge and a clear hit the same bit in the same cycle, the edge wins and the bit stays 1.
- irq is registered: irq <= |(cap & mask), so it asserts 1 cycle after a capture bit or mask bit sets.
- Latency from in_port to a visible capture bit, DEBOUNCE_CYCLES = 0, rising edge:
  - SYNC_STAGES cycles to s, +1 to deb, +1 to cap, +1 to irq.
  - With defaults, cap is set 4 cycles after the in_port sample edge and irq 5 cycles after.
- Reset asserted mid-operation clears everything immediately and warmup restarts.
- Mask changes take effect on irq the next cycle; masking never clears cap.

Decomposition:
- Shared package sys_pio_pkg holds:
  - address constants PIO_ADDR_DATA = 0, PIO_ADDR_MASK = 2, PIO_ADDR_EDGE = 3;
  - edge-type constants EDGE_RISE = 0, EDGE_FALL = 1, EDGE_ANY = 2;
  - the PIO data width constant of 32.
- One sub-module, sys_pio_debounce: a per-bit counter plus stable register with parameter DEBOUNCE_CYCLES, instantiated WIDTH times in a generate loop.
- Synchroniser, edge detect, capture and Avalon decode stay in sys_pio_in.

Test Plan:
- Reset values, in_port held at 32'hFFFF_FFFF through reset release, defaults -> readdata = 0 during reset; after 10 cycles EDGE_CAP reads 0, DATA reads 32'hFFFF_FFFF, irq = 0.
- Rising edge, defaults: write MASK = 32'h0000_0001, then drive in_port[0] 0->1 -> EDGE_CAP bit0 = 1 at cycle +4, irq = 1 at +5; writing EDGE_CAP with 32'h1 -> irq = 0 two cycles later.
- Masking: edge on bit 5 with MASK = 0 -> EDGE_CAP = 32'h20, irq stays 0; then write MASK = 32'h20 -> irq = 1 next cycle.
- Same-cycle edge and clear: bit 3 already captured; write-1-clear bit 3 in the same cycle a new rising edge reaches cap -> EDGE_CAP bit3 remains 1.
- Debounce, DEBOUNCE_CYCLES = 4, EDGE_TYPE = 2:
  - a 3-cycle pulse on in_port[7] -> DATA bit7 and EDGE_CAP stay 0;
  - a 6-cycle pulse -> DATA bit7 goes 1 and then back to 0, EDGE_CAP bit7 = 1.
- Reset mid-operation: EDGE_CAP = 32'hF and irq = 1, assert reset_n for 1 cycle -> irq, EDGE_CAP, MASK all 0 immediately; no capture during the subsequent warmup.
